// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the RV32M iterative divider: op encodings, FSM states
// and small op-decoding helpers.
package iterative_divider_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    case (op)
      OP_DIV, OP_REM: op_is_signed = 1'b1;
      default:        op_is_signed = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    case (op)
      OP_REM, OP_REMU: op_is_rem = 1'b1;
      default:         op_is_rem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and subtracts the divisor if it fits.
module iterative_divider_div_step
  import iterative_divider_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            q_msb_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // The partial remainder stays below the divisor, so a restored trial never
  // needs its top bit; the XLEN+1-bit difference sign is the compare result.
  always_comb begin
    trial = {rem_i, q_msb_i};
    diff  = trial - {1'b0, divisor_i};
    if (!diff[XLEN]) begin
      rem_o   = diff[XLEN-1:0];
      q_bit_o = 1'b1;
    end else begin
      rem_o   = trial[XLEN-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU), one quotient bit per cycle,
// with start/busy/valid handshake and flush support.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             rem_sel_q, rem_sel_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             signed_op;
  logic             rem_op;
  logic [XLEN-1:0]  dividend_abs;
  logic [XLEN-1:0]  divisor_abs;
  logic [XLEN-1:0]  step_rem;
  logic             step_bit;

  iterative_divider_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (rem_q),
    .q_msb_i   (quo_q[XLEN-1]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rem_sel_d  = rem_sel_q;
    result_d   = result_q;

    signed_op    = op_is_signed(div_op_e'(div_op_i));
    rem_op       = op_is_rem(div_op_e'(div_op_i));
    dividend_abs = (signed_op && dividend_i[XLEN-1]) ? twos_neg(dividend_i) : dividend_i;
    divisor_abs  = (signed_op && divisor_i[XLEN-1]) ? twos_neg(divisor_i) : divisor_i;

    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          rem_sel_d  = rem_op;
          neg_quot_d = signed_op & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
          neg_rem_d  = signed_op & dividend_i[XLEN-1];
          if (divisor_i == {XLEN{1'b0}}) begin
            result_d = rem_op ? dividend_i : {XLEN{1'b1}};
            state_d  = DONE;
          end else if (signed_op && (dividend_i == SIGNED_MIN) &&
                       (divisor_i == {XLEN{1'b1}})) begin
            result_d = rem_op ? {XLEN{1'b0}} : SIGNED_MIN;
            state_d  = DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            rem_d   = {XLEN{1'b0}};
            quo_d   = dividend_abs;
            dvsr_d  = divisor_abs;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[XLEN-2:0], step_bit};
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = FIXUP;
          end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      FIXUP: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (rem_sel_q) begin
            result_d = neg_rem_q ? twos_neg(rem_q) : rem_q;
          end else begin
            result_d = neg_quot_q ? twos_neg(quo_q) : quo_q;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      rem_q      <= {XLEN{1'b0}};
      quo_q      <= {XLEN{1'b0}};
      dvsr_q     <= {XLEN{1'b0}};
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
      result_q   <= {XLEN{1'b0}};
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rem_sel_q  <= rem_sel_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: arithmetic reference model plus a
// cycle-level handshake model checked every cycle, and literal expectations.
module tb_iterative_divider;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  div_op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Handshake model: active op, cycles left until its valid cycle, result.
  bit          m_active = 1'b0;
  int          m_left   = 0;
  logic [31:0] m_pend   = 32'h0;
  logic [31:0] m_res    = 32'h0;

  iterative_divider dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .div_op_i   (div_op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) begin
      sa = a;
      sb = b;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_active <= 1'b0;
      m_left   <= 0;
      m_res    <= 32'h0;
    end else if (m_active) begin
      if (m_left == 0 || flush_i) begin
        m_active <= 1'b0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) m_res <= m_pend;
      end
    end else if (start_i && !flush_i) begin
      m_active <= 1'b1;
      m_pend   <= ref_div(div_op_i, dividend_i, divisor_i);
      if (is_special(div_op_i, dividend_i, divisor_i)) begin
        m_left <= 0;
        m_res  <= ref_div(div_op_i, dividend_i, divisor_i);
      end else begin
        m_left <= 33;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("cycle busy_o", 32'(busy_o), 32'(m_active));
      chk("cycle valid_o", 32'(valid_o), 32'(m_active && m_left == 0));
      chk("cycle result_o", result_o, m_res);
    end
  end

  // Called at a negedge: start is high for exactly one cycle.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_op_i   = op;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp, input int exp_lat, input int lat0);
    int lat;
    lat = lat0;
    while (valid_o !== 1'b1 && lat < 80) begin
      @(negedge clk_i);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, result_o, exp);
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    chk({name, " model"}, ref_div(op, a, b), exp);
    @(negedge clk_i);
    issue(op, a, b);
    wait_valid(name, exp, exp_lat, 1);
  endtask

  initial begin
    int seen;
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    div_op_i   = 2'b00;
    dividend_i = 32'h0;
    divisor_i  = 32'h0;
    repeat (2) @(negedge clk_i);
    chk("reset busy_o", 32'(busy_o), 32'h0);
    chk("reset valid_o", 32'(valid_o), 32'h0);
    chk("reset result_o", result_o, 32'h0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    do_op("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14, 34);
    do_op("REMU 100/7", REMU, 32'd100, 32'd7, 32'd2, 34);
    do_op("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("DIVU max/1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    do_op("DIV 20/-3", DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
    do_op("REM 20/-3", REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 34);
    do_op("DIV min/2", DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);
    do_op("DIVU min/max", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
    do_op("REMU min/max", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    do_op("DIVU by zero", DIVU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1);
    do_op("REM by zero", REM, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);
    do_op("DIV overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("REM overflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // A start pulse at N+5 while busy must not disturb the running op.
    @(negedge clk_i);
    issue(DIVU, 32'd1000, 32'd3);
    repeat (4) @(negedge clk_i);
    div_op_i   = DIV;
    dividend_i = 32'd7;
    divisor_i  = 32'h0;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    wait_valid("ignored start", 32'd333, 34, 6);

    // Flush at N+10 aborts; a new start at N+11 completes at N+45.
    @(negedge clk_i);
    issue(DIVU, 32'd2000, 32'd7);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush busy_o", 32'(busy_o), 32'h0);
    chk("flush result_o held", result_o, 32'd333);
    issue(DIV, 32'd1000, 32'hFFFF_FFFD);
    wait_valid("after flush", 32'hFFFF_FEB3, 34, 1);

    // Flush together with start in IDLE: start is dropped.
    @(negedge clk_i);
    div_op_i   = DIVU;
    dividend_i = 32'd9;
    divisor_i  = 32'd3;
    start_i    = 1'b1;
    flush_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    flush_i    = 1'b0;
    chk("flush+start busy_o", 32'(busy_o), 32'h0);
    repeat (3) @(negedge clk_i);
    chk("flush+start result_o", result_o, 32'hFFFF_FEB3);

    // Reset pulse at N+20 aborts the op and clears the outputs.
    @(negedge clk_i);
    issue(DIVU, 32'd1000, 32'd3);
    repeat (19) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("mid reset busy_o", 32'(busy_o), 32'h0);
    chk("mid reset valid_o", 32'(valid_o), 32'h0);
    chk("mid reset result_o", result_o, 32'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen++;
    end
    chk("valid after reset", 32'(seen), 32'h0);

    do_op("DIVU after reset", DIVU, 32'd100, 32'd7, 32'd14, 34);

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
